// File: rtl/mult_share_arbiter.sv
// -----------------------------------------------------------------------------
// mult_share_arbiter
//
// Shares one fixed-latency arithmetic unit (multiplier / MAC stage) among four
// requesters. A winner is chosen in IDLE, its operand is issued for one cycle,
// the unit latency is counted down, and the result is captured and returned
// with a one-cycle acknowledge to the owner.
//
// Optional feature macro: MULT_ARB_FIXED_PRIO_EN
//   defined     : fixed priority, req_i[0] > req_i[1] > req_i[2] > req_i[3]
//   not defined : round-robin starting after the last winner (default)
//
// Parameters
//   N   : operand/result width in bits
//   LAT : shared-unit latency in cycles (1..15)
//
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   req_i        in   per-requester request, held until the matching ack
//   din0_i..3_i  in   requester operands, stable while the request is high
//   sel_o        out  operand mux select, equals the granted index
//   grant_o      out  one-hot owner of the shared unit, 0 when idle
//   unit_in_o    out  operand to the shared unit (din[sel])
//   unit_valid_o out  one-cycle issue strobe to the shared unit
//   unit_out_i   in   unit result, valid LAT cycles after unit_valid_o
//   result_o     out  captured result
//   ack_o        out  one-hot one-cycle completion pulse to the owner
//   busy_o       out  high whenever the sequencer is not idle
// -----------------------------------------------------------------------------
module mult_share_arbiter #(
   parameter int N   = 4,
   parameter int LAT = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [3:0]   req_i,
   input  logic [N-1:0] din0_i,
   input  logic [N-1:0] din1_i,
   input  logic [N-1:0] din2_i,
   input  logic [N-1:0] din3_i,
   output logic [1:0]   sel_o,
   output logic [3:0]   grant_o,
   output logic [N-1:0] unit_in_o,
   output logic         unit_valid_o,
   input  logic [N-1:0] unit_out_i,
   output logic [N-1:0] result_o,
   output logic [3:0]   ack_o,
   output logic         busy_o
);

   localparam logic [3:0] LAT_C = 4'(LAT);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t       state_q, state_d;
   logic [1:0]   ptr_q, ptr_d;
   logic [1:0]   sel_q, sel_d;
   logic [3:0]   grant_q, grant_d;
   logic [3:0]   cnt_q, cnt_d;
   logic         uv_q, uv_d;
   logic [3:0]   ack_q, ack_d;
   logic [N-1:0] result_q, result_d;
   logic         busy_q, busy_d;

   logic         win_found;
   logic [1:0]   win_idx;

   // Winner search over the current request vector
   always_comb begin
      win_found = |req_i;
      win_idx   = 2'd0;
`ifdef MULT_ARB_FIXED_PRIO_EN
      // Walk from lowest priority to highest so the last hit is the winner
      for (int i = 3; i >= 0; i--) begin
         win_idx = req_i[i] ? 2'(i) : win_idx;
      end
`else
      // Candidates ptr+4 .. ptr+1 visited in reverse; ptr+1 ends up preferred
      for (int k = 3; k >= 0; k--) begin
         win_idx = req_i[ptr_q + 2'd1 + 2'(k)] ? (ptr_q + 2'd1 + 2'(k)) : win_idx;
      end
`endif
   end

   // Operand mux into the shared unit
   always_comb begin
      unit_in_o = din0_i;
      case (sel_q)
         2'd0:    unit_in_o = din0_i;
         2'd1:    unit_in_o = din1_i;
         2'd2:    unit_in_o = din2_i;
         2'd3:    unit_in_o = din3_i;
         default: unit_in_o = din0_i;
      endcase
   end

   // Next-state and next-output logic of the sequencer
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      sel_d    = sel_q;
      grant_d  = grant_q;
      cnt_d    = cnt_q;
      uv_d     = 1'b0;
      ack_d    = 4'b0000;
      result_d = result_q;
      case (state_q)
         S_IDLE: begin
            if (win_found) begin
               state_d = S_ISSUE;
               sel_d   = win_idx;
               ptr_d   = win_idx;
               grant_d = 4'b0001 << win_idx;
               uv_d    = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ISSUE: begin
            cnt_d   = LAT_C;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // Count value 1 marks the cycle in which unit_out_i is valid
            if (cnt_q == 4'd1) begin
               result_d = unit_out_i;
               ack_d    = grant_q;
               cnt_d    = 4'd0;
               state_d  = S_DONE;
            end else begin
               cnt_d    = cnt_q - 4'd1;
            end
         end
         S_DONE: begin
            grant_d = 4'b0000;
            state_d = S_IDLE;
         end
         default: begin
            grant_d = 4'b0000;
            state_d = S_IDLE;
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         ptr_q    <= 2'd3;
         sel_q    <= 2'd0;
         grant_q  <= 4'b0000;
         cnt_q    <= 4'd0;
         uv_q     <= 1'b0;
         ack_q    <= 4'b0000;
         result_q <= '0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         sel_q    <= sel_d;
         grant_q  <= grant_d;
         cnt_q    <= cnt_d;
         uv_q     <= uv_d;
         ack_q    <= ack_d;
         result_q <= result_d;
         busy_q   <= busy_d;
      end
   end

   assign sel_o        = sel_q;
   assign grant_o      = grant_q;
   assign unit_valid_o = uv_q;
   assign ack_o        = ack_q;
   assign result_o     = result_q;
   assign busy_o       = busy_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// -----------------------------------------------------------------------------
// Scoreboard bench for mult_share_arbiter. Requester agents raise requests,
// a transaction-level model predicts the winner and its timing whenever the
// arbiter is free, and a monitor compares issue strobes and acks against the
// predicted queues. A behavioural unit returns operand+1 exactly LAT cycles
// after issue and random junk in every other cycle.
// -----------------------------------------------------------------------------
module tb_mult_share_arbiter #(parameter int LAT = 3);

   localparam int N = 4;

   typedef struct {
      int           idx;
      logic [N-1:0] val;
      int           t;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [3:0]   req = 4'b0000;
   logic [N-1:0] din [4];
   logic [1:0]   sel_o;
   logic [3:0]   grant_o;
   logic [N-1:0] unit_in_o;
   logic         unit_valid_o;
   logic [N-1:0] unit_out = '0;
   logic [N-1:0] result_o;
   logic [3:0]   ack_o;
   logic         busy_o;

   exp_t issue_q[$];
   exp_t ack_q[$];
   int   won_q[$];
   int   total = 0;
   int   bad = 0;
   int   tick = 0;
   int   free_tick = 0;
   int   m_ptr = 3;
   int   unit_due = -1;
   int   idle_tick = -1;
   logic [N-1:0] unit_arg = '0;
   logic [3:0]   en_mask = 4'b0000;
   bit           force_raise = 1'b0;
   bit           hold_all = 1'b0;
   bit           use_fixed = 1'b0;
   logic [N-1:0] fixed_din = '0;
   int           exp_order [5];

   mult_share_arbiter #(.N(N), .LAT(LAT)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_i        (req),
      .din0_i       (din[0]),
      .din1_i       (din[1]),
      .din2_i       (din[2]),
      .din3_i       (din[3]),
      .sel_o        (sel_o),
      .grant_o      (grant_o),
      .unit_in_o    (unit_in_o),
      .unit_valid_o (unit_valid_o),
      .unit_out_i   (unit_out),
      .result_o     (result_o),
      .ack_o        (ack_o),
      .busy_o       (busy_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) tick <= tick + 1;

   function automatic void chk(string nm, longint act, longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: actual=%0d required=%0d tick=%0d", nm, act, exp, tick);
      end
   endfunction

   // Arbitration rule: first requester after the last winner, cyclically
   function automatic int pick(logic [3:0] r, int p);
`ifdef MULT_ARB_FIXED_PRIO_EN
      for (int i = 0; i < 4; i++) if (r[i]) return i;
`else
      for (int k = 1; k <= 4; k++) if (r[(p + k) % 4]) return (p + k) % 4;
`endif
      return -1;
   endfunction

   // One cycle of requester behaviour plus the transaction-level prediction
   task automatic step();
      logic [3:0] dropped;
      exp_t e;
      int   w;
      dropped = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         if (req[i] && ack_o[i] && !hold_all) begin
            req[i] = 1'b0;
            dropped[i] = 1'b1;
         end
      end
      for (int i = 0; i < 4; i++) begin
         if (!req[i] && !dropped[i] && en_mask[i] &&
             (force_raise || $urandom_range(0, 2) == 0)) begin
            din[i] = use_fixed ? fixed_din : N'($urandom);
            req[i] = 1'b1;
         end
      end
      if (tick >= free_tick && req != 4'b0000) begin
         w = pick(req, m_ptr);
         m_ptr = w;
         e.idx = w;
         e.val = din[w];
         e.t   = tick + 1;
         issue_q.push_back(e);
         e.val = din[w] + N'(1);
         e.t   = tick + LAT + 2;
         ack_q.push_back(e);
         free_tick = tick + LAT + 3;
      end
      @(negedge clk);
   endtask

   task automatic clear_model();
      issue_q.delete();
      ack_q.delete();
      req = 4'b0000;
      m_ptr = 3;
      free_tick = 0;
      idle_tick = -1;
   endtask

   task automatic check_reset_outputs();
      chk("rst_sel", sel_o, 0);
      chk("rst_grant", grant_o, 0);
      chk("rst_unit_valid", unit_valid_o, 0);
      chk("rst_ack", ack_o, 0);
      chk("rst_result", result_o, 0);
      chk("rst_busy", busy_o, 0);
   endtask

   // Behavioural shared unit: operand+1 exactly LAT cycles after issue
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            unit_due = -1;
         end else if (unit_valid_o) begin
            unit_due = tick + LAT;
            unit_arg = unit_in_o;
         end
         if (rst_n && unit_due == tick) unit_out = unit_arg + N'(1);
         else unit_out = N'($urandom);
      end
   end

   // Monitor: pops predictions whenever the DUT issues or acknowledges
   initial begin
      exp_t e;
      int   a;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (unit_valid_o) begin
               if (issue_q.size() == 0) begin
                  chk("issue_spurious", issue_q.size(), 1);
               end else begin
                  e = issue_q.pop_front();
                  chk("issue_tick", tick, e.t);
                  chk("issue_sel", sel_o, e.idx);
                  chk("issue_grant", grant_o, longint'(1) << e.idx);
                  chk("issue_operand", unit_in_o, e.val);
               end
            end
            if (ack_o != 4'b0000) begin
               a = -1;
               for (int i = 0; i < 4; i++) if (ack_o[i]) a = i;
               won_q.push_back(a);
               if (ack_q.size() == 0) begin
                  chk("ack_spurious", ack_q.size(), 1);
               end else begin
                  e = ack_q.pop_front();
                  chk("ack_tick", tick, e.t);
                  chk("ack_vec", ack_o, longint'(1) << e.idx);
                  chk("ack_result", result_o, e.val);
                  chk("done_grant", grant_o, longint'(1) << e.idx);
                  chk("done_sel", sel_o, e.idx);
                  chk("done_busy", busy_o, 1);
                  idle_tick = tick + 1;
               end
            end
            if (tick == idle_tick) begin
               chk("idle_grant", grant_o, 0);
               chk("idle_busy", busy_o, 0);
            end
         end
      end
   end

   initial begin
`ifdef MULT_ARB_FIXED_PRIO_EN
      exp_order = '{0, 0, 0, 0, 0};
`else
      exp_order = '{0, 1, 2, 3, 0};
`endif
      for (int i = 0; i < 4; i++) din[i] = '0;
      @(negedge clk);
      @(negedge clk);
      check_reset_outputs();
      rst_n = 1'b1;

      // Single request, operand 4'hA
      use_fixed = 1'b1;
      fixed_din = N'(10);
      force_raise = 1'b1;
      en_mask = 4'b0001;
      step();
      en_mask = 4'b0000;
      repeat (LAT + 6) step();

      // All four requesters held high from reset
      rst_n = 1'b0;
      clear_model();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      won_q.delete();
      use_fixed = 1'b0;
      hold_all = 1'b1;
      en_mask = 4'b1111;
      step();
      repeat (5 * (LAT + 3) + 2) step();
      hold_all = 1'b0;
      en_mask = 4'b0000;
      repeat (5 * (LAT + 3) + 4) step();
      chk("order_len", won_q.size() >= 5, 1);
      for (int k = 0; k < 5; k++) begin
         if (k < won_q.size()) chk("order", won_q[k], exp_order[k]);
      end

      // Request 2 alone, then 1 joins: 2 is served before 1
      won_q.delete();
      en_mask = 4'b0100;
      step();
      en_mask = 4'b0110;
      step();
      en_mask = 4'b0000;
      repeat (3 * (LAT + 3) + 2) step();
      chk("pair_len", won_q.size(), 2);
      if (won_q.size() >= 2) begin
         chk("pair_first", won_q[0], 2);
         chk("pair_second", won_q[1], 1);
      end

      // Randomized traffic from all requesters
      force_raise = 1'b0;
      en_mask = 4'b1111;
      repeat (300) step();
      en_mask = 4'b0000;
      repeat (6 * (LAT + 3)) step();

      // Reset while the transaction is waiting on the unit
      force_raise = 1'b1;
      en_mask = 4'b0001;
      step();
      en_mask = 4'b0000;
      step();
      rst_n = 1'b0;
      #1;
      check_reset_outputs();
      clear_model();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      use_fixed = 1'b1;
      fixed_din = N'(5);
      en_mask = 4'b0001;
      step();
      en_mask = 4'b0000;
      repeat (LAT + 6) step();

      chk("issue_q_drained", issue_q.size(), 0);
      chk("ack_q_drained", ack_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mult_share_arbiter.md
# mult_share_arbiter

Round-robin arbiter and sequencer that shares one fixed-latency arithmetic unit (multiplier / MAC stage of the pseudoinverse datapath) among four requesters. It drives the 2-bit select of the 4:1 operand multiplexer, issues one operand word per transaction into the shared unit, and counts the unit latency. It then captures the result and returns it with a one-cycle acknowledge to the owning requester. Sits between the matrix-element sequencers and the shared arithmetic pipeline.

## Interface
- N, default 4: operand/result width in bits.
- LAT, default 3: shared-unit latency in cycles, legal range 1..15.

- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  4  per-requester request; held high until the matching ack.
- din0, din1, din2, din3  in  N each  requester operands; held stable while the matching req is high.
- sel  out  2  select for the 4:1 operand mux; equals the granted index.
- grant  out  4  one-hot owner of the shared unit; 0 when idle.
- unit_in  out  N  operand to the shared unit, combinational mux of din[sel].
- unit_valid  out  1  one-cycle issue strobe to the shared unit.
- unit_out  in  N  shared-unit result, valid exactly LAT cycles after unit_valid.
- result  out  N  registered captured result.
- ack  out  4  one-hot, one-cycle completion pulse to the owner.
- busy  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: if any req bit is high, choose a winner, register sel/grant, go to ISSUE. Otherwise stay.
- Round-robin pointer ptr (2 bits) holds the last winner. Search order is ptr+1, ptr+2, ptr+3, ptr (mod 4). The first requester found wins. ptr updates to the winner on entry to ISSUE.
- ISSUE (1 cycle): unit_valid=1, unit_in=din[sel]. Load counter with LAT, go to WAIT.
- WAIT: decrement counter each cycle. When counter reaches 1 (the cycle unit_out is valid), register result<=unit_out and ack<=onehot(sel), then go to DONE.
- DONE (1 cycle): ack visible. grant and sel held. Next state IDLE, with grant cleared on exit.
- Requester protocol: req[i] must drop in the cycle after ack[i] is seen. A req[i] still high in IDLE after DONE is a new request.
- Counter width is 4 bits; LAT outside 1..15 is unsupported.
- req bits that drop before a grant are simply not selected. A granted req that drops mid-transaction does not abort it; ack is still produced.

## Timing
- Reset values (asynchronous, immediate): state=IDLE, ptr=3 (req[0] first priority), sel=0, grant=0, unit_valid=0, ack=0, result=0, busy=0, counter=0.
- Cycle numbering from the cycle req is first sampled high in IDLE (cycle 0):
  - cycle 1: ISSUE, unit_valid=1.
  - cycles 2..LAT: WAIT.
  - cycle LAT+1: capture from unit_out.
  - cycle LAT+2: DONE, ack=1.
  - cycle LAT+3: IDLE.
- Latency from req to ack: LAT+2 cycles.
- Throughput: one transaction per LAT+3 cycles.
- grant/sel are stable from ISSUE through DONE inclusive.
- Reset mid-transaction returns to IDLE with no ack. The in-flight unit result is discarded; the requester must re-request.

## Configuration
- MULT_ARB_FIXED_PRIO_EN defined: fixed priority, req[0] > req[1] > req[2] > req[3]. ptr is not used for selection.
- Not defined: round-robin as described above (default).

## Test plan
- Single request, LAT=3: req=0001 and din0=4'hA; unit model returns din+1. Required: unit_valid in cycle 1, ack=0001 in cycle 5, result=4'hB, grant=0 in cycle 6.
- All four requesters held high continuously from reset: grants in order 0,1,2,3,0. Each ack arrives 6 cycles after the previous one; sel matches grant on every transaction.
- Sequence req=0100 then req=0110: after index 2 is served, index 1 wins only after ptr wraps (order 2 then 1). No requester is starved over 8 transactions.
- rst_n asserted during WAIT: all outputs return to reset values immediately. No ack is produced, and a subsequent req=0001 completes normally.
- LAT=1 and LAT=15 builds: ack latency is 3 and 17 cycles respectively. result matches the unit_out sampled exactly LAT cycles after unit_valid.
- MULT_ARB_FIXED_PRIO_EN build, req=1111 held: index 0 is served every transaction and grant never moves to 1, 2 or 3.
